// File: rtl/fb_pkg.sv
// fb_pkg: shared types and constants for the framebuffer line reader.
//   state_t          : reader FSM states (IDLE, WAIT, READ)
//   *_DEF            : default geometry and data widths
//   LAT              : fb_addr -> lb_en/lb_colr latency; 3 when FB_READ_REG_EN
//                      is defined (extra fb_cidx register), otherwise 2
package fb_pkg;

    localparam int unsigned FB_WIDTH_DEF  = 320;
    localparam int unsigned FB_HEIGHT_DEF = 240;
    localparam int unsigned FB_DATAW_DEF  = 4;
    localparam int unsigned COLRW_DEF     = 12;

`ifdef FB_READ_REG_EN
    localparam int unsigned LAT = 3;
`else
    localparam int unsigned LAT = 2;
`endif

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READ
    } state_t;

endpackage

// File: rtl/fb_read_pipe.sv
// fb_read_pipe: valid/data delay line of DEPTH stages.
//   clk_i    in   clock
//   rst_i    in   synchronous active-high reset
//   flush_i  in   synchronous flush; clears every valid bit
//   valid_i  in   valid entering the line
//   data_i   in   DW-bit sideband entering the line
//   valid_o  out  valid delayed by DEPTH cycles
//   data_o   out  sideband delayed by DEPTH cycles
module fb_read_pipe #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned DW    = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    logic [DEPTH-1:0] valid_q;
    logic [DW-1:0]    data_q [DEPTH];

    // Flush wins over the incoming valid so a pixel issued in the flush
    // cycle never reaches the output.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= valid_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            data_q[0] <= data_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/fb_line_reader.sv
// fb_line_reader: streams one framebuffer line per line_req into the
// linebuffer, mapping each colour index through the external palette ROM.
//   clk         in   pixel clock
//   rst         in   synchronous active-high reset
//   frame_start in   arms a new frame; resets address/counters, flushes pipe
//   line_req    in   linebuffer data request pulse
//   fb_addr     out  registered framebuffer read address
//   fb_cidx     in   framebuffer read data, one cycle after fb_addr
//   clut_idx    out  palette ROM address
//   clut_colr   in   palette ROM data (combinational from clut_idx)
//   lb_en       out  linebuffer write enable
//   lb_colr     out  linebuffer colour
//   busy        out  high while a line is being issued
//   frame_done  out  pulse with the last lb_en of the frame
//   err_req     out  sticky: line_req seen while busy; cleared by frame_start
// Optional: define FB_READ_REG_EN to register fb_cidx before clut_idx
// (latency 3 instead of 2).
module fb_line_reader
    import fb_pkg::*;
#(
    parameter int unsigned FB_WIDTH  = FB_WIDTH_DEF,
    parameter int unsigned FB_HEIGHT = FB_HEIGHT_DEF,
    parameter int unsigned FB_ADDRW  = $clog2(FB_WIDTH * FB_HEIGHT),
    parameter int unsigned FB_DATAW  = FB_DATAW_DEF,
    parameter int unsigned COLRW     = COLRW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    input  logic                line_req,
    output logic [FB_ADDRW-1:0] fb_addr,
    input  logic [FB_DATAW-1:0] fb_cidx,
    output logic [FB_DATAW-1:0] clut_idx,
    input  logic [COLRW-1:0]    clut_colr,
    output logic                lb_en,
    output logic [COLRW-1:0]    lb_colr,
    output logic                busy,
    output logic                frame_done,
    output logic                err_req
);

    localparam int unsigned PIXW  = $clog2(FB_WIDTH);
    localparam int unsigned LINEW = $clog2(FB_HEIGHT);

    localparam logic [PIXW-1:0]     PIX_LAST  = PIXW'(FB_WIDTH - 1);
    localparam logic [LINEW-1:0]    LINE_LAST = LINEW'(FB_HEIGHT - 1);
    localparam logic [PIXW-1:0]     PIX_ONE   = PIXW'(1);
    localparam logic [LINEW-1:0]    LINE_ONE  = LINEW'(1);
    localparam logic [FB_ADDRW-1:0] ADDR_ONE  = FB_ADDRW'(1);

    state_t              state_q, state_d;
    logic [FB_ADDRW-1:0] addr_q,  addr_d;
    logic [PIXW-1:0]     pix_q,   pix_d;
    logic [LINEW-1:0]    line_q,  line_d;
    logic                err_q,   err_d;
    logic [COLRW-1:0]    colr_q;

    logic issue_valid;
    logic issue_last;
    logic last_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            pix_q   <= '0;
            line_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pix_d       = pix_q;
        line_d      = line_q;
        err_d       = err_q;
        issue_valid = (state_q == READ);
        issue_last  = (state_q == READ) && (pix_q == PIX_LAST) && (line_q == LINE_LAST);

        if (frame_start) begin
            state_d = WAIT;
            addr_d  = '0;
            pix_d   = '0;
            line_d  = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                WAIT: begin
                    if (line_req) begin
                        state_d = READ;
                    end
                end
                READ: begin
                    if (line_req) begin
                        err_d = 1'b1;
                    end
                    if (pix_q == PIX_LAST) begin
                        pix_d = '0;
                        if (line_q == LINE_LAST) begin
                            // Address parks on the final pixel until re-armed.
                            state_d = IDLE;
                        end else begin
                            line_d  = line_q + LINE_ONE;
                            addr_d  = addr_q + ADDR_ONE;
                            state_d = WAIT;
                        end
                    end else begin
                        pix_d  = pix_q + PIX_ONE;
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Valid and end-of-frame marker travel together so frame_done lines up
    // with the final lb_en.
    fb_read_pipe #(
        .DEPTH(LAT),
        .DW   (1)
    ) u_pipe (
        .clk_i  (clk),
        .rst_i  (rst),
        .flush_i(frame_start),
        .valid_i(issue_valid),
        .data_i (issue_last),
        .valid_o(lb_en),
        .data_o (last_out)
    );

`ifdef FB_READ_REG_EN
    logic [FB_DATAW-1:0] cidx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cidx_q <= '0;
        end else begin
            cidx_q <= fb_cidx;
        end
    end

    assign clut_idx = cidx_q;
`else
    assign clut_idx = fb_cidx;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            colr_q <= '0;
        end else begin
            colr_q <= clut_colr;
        end
    end

    assign fb_addr    = addr_q;
    assign lb_colr    = colr_q;
    assign busy       = (state_q == READ);
    assign frame_done = lb_en & last_out;
    assign err_req    = err_q;

endmodule

// File: tb/tb_fb_line_reader.sv
module tb_fb_line_reader;

    localparam int unsigned W  = 320;
    localparam int unsigned H  = 240;
    localparam int unsigned AW = 17;
`ifdef FB_READ_REG_EN
    localparam int unsigned TB_LAT = 3;
`else
    localparam int unsigned TB_LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic          line_req;
    logic [AW-1:0] fb_addr;
    logic [3:0]    fb_cidx;
    logic [3:0]    clut_idx;
    logic [11:0]   clut_colr;
    logic          lb_en;
    logic [11:0]   lb_colr;
    logic          busy;
    logic          frame_done;
    logic          err_req;

    fb_line_reader #(
        .FB_WIDTH (W),
        .FB_HEIGHT(H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .line_req   (line_req),
        .fb_addr    (fb_addr),
        .fb_cidx    (fb_cidx),
        .clut_idx   (clut_idx),
        .clut_colr  (clut_colr),
        .lb_en      (lb_en),
        .lb_colr    (lb_colr),
        .busy       (busy),
        .frame_done (frame_done),
        .err_req    (err_req)
    );

    // Framebuffer contents: nibble-xor of the address.
    function automatic logic [3:0] fbmem(input logic [AW-1:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ {3'b000, a[16]};
    endfunction

    function automatic logic [11:0] pal(input logic [3:0] i);
        case (i)
            4'd0:  return 12'h000;
            4'd1:  return 12'h00F;
            4'd2:  return 12'h0F0;
            4'd3:  return 12'hF00;
            4'd4:  return 12'h0FF;
            4'd5:  return 12'hF0F;
            4'd6:  return 12'hFF0;
            4'd7:  return 12'hFFF;
            4'd8:  return 12'h123;
            4'd9:  return 12'h456;
            4'd10: return 12'h789;
            4'd11: return 12'hABC;
            4'd12: return 12'hDEF;
            4'd13: return 12'h321;
            4'd14: return 12'h654;
            default: return 12'h987;
        endcase
    endfunction

    always #5 clk = ~clk;

    always @(posedge clk) fb_cidx <= fbmem(fb_addr);
    assign clut_colr = pal(clut_idx);

    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned fd_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] colr;
        int unsigned at;
        bit          last;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every lb_en must match the oldest expected pixel.
    always @(negedge clk) begin
        exp_t e;
        if (frame_done === 1'b1) fd_count++;
        if (lb_en === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_lb_en: lb_en=1 colr=%h at cycle %0d, expected no write", lb_colr, cyc);
            end else begin
                e = sb.pop_front();
                chk("lb_colr", lb_colr, e.colr);
                chk("lb_cycle", cyc, e.at);
                chk("frame_done_on_last", frame_done, e.last);
            end
        end else if (frame_done === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL frame_done_without_lb_en: frame_done=1 lb_en=0 at cycle %0d, expected 0", cyc);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_pixels(input int unsigned base, input int unsigned r,
                               input bit last_line, input int unsigned npix);
        exp_t e;
        for (int unsigned k = 0; k < npix; k++) begin
            e.colr = pal(fbmem(AW'(base + k)));
            e.at   = r + 1 + k + TB_LAT;
            e.last = last_line && (k == W - 1);
            sb.push_back(e);
        end
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pulse_req();
        line_req = 1'b1;
        tick();
        line_req = 1'b0;
    endtask

    // Issue line l and return at the earliest cycle the next request is accepted.
    task automatic run_line(input int unsigned l, input bit last_line);
        int unsigned r;
        r = cyc;
        push_pixels(l * W, r, last_line, W);
        pulse_req();
        chk("line_first_addr", fb_addr, l * W);
        repeat (W - 1) tick();
        chk("line_last_addr", fb_addr, l * W + W - 1);
        chk("busy_last_pixel", busy, 1);
        tick();
    endtask

    task automatic wait_drain(input int unsigned limit);
        int unsigned n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected pixels never appeared, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int unsigned r;
        int unsigned fd0;
        int unsigned en_seen;

        rst = 1'b1;
        frame_start = 1'b0;
        line_req = 1'b0;
        repeat (3) tick();

        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_lb_en", lb_en, 0);
        chk("rst_lb_colr", lb_colr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err_req", err_req, 0);
        rst = 1'b0;
        tick();

        // line_req in IDLE is ignored.
        pulse_req();
        repeat (10) tick();
        chk("idle_req_busy", busy, 0);

        // Single line with per-cycle address check.
        pulse_fs();
        chk("fs_addr", fb_addr, 0);
        r = cyc;
        push_pixels(0, r, 1'b0, W);
        pulse_req();
        for (int unsigned k = 0; k < W; k++) begin
            chk("l0_addr", fb_addr, k);
            chk("l0_busy", busy, 1);
            tick();
        end
        chk("l0_busy_after", busy, 0);
        wait_drain(20);

        // Reset mid-line: pixels already past the point of no return still
        // emerge; nothing after.
        r = cyc;
        push_pixels(W, r, 1'b0, 51 - TB_LAT);
        pulse_req();
        repeat (50) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_lb_en", lb_en, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_addr", fb_addr, 0);
        pulse_req();
        repeat (10) tick();
        chk("rst_mid_req_busy", busy, 0);
        wait_drain(5);

        // Full frame, back-to-back requests.
        pulse_fs();
        fd0 = fd_count;
        for (int unsigned l = 0; l < H; l++) begin
            run_line(l, l == H - 1);
        end
        wait_drain(20);
        chk("frame_done_count", fd_count - fd0, 1);
        chk("idle_addr_hold", fb_addr, W * H - 1);
        chk("idle_busy", busy, 0);
        en_seen = 0;
        pulse_req();
        for (int unsigned i = 0; i < 330; i++) begin
            if (lb_en === 1'b1) en_seen++;
            tick();
        end
        chk("req_241_lb_en_count", en_seen, 0);
        chk("req_241_addr", fb_addr, W * H - 1);

        // line_req during READ.
        pulse_fs();
        r = cyc;
        push_pixels(0, r, 1'b0, W);
        pulse_req();
        repeat (100) tick();
        chk("err_before", err_req, 0);
        pulse_req();
        chk("err_set", err_req, 1);
        chk("err_busy", busy, 1);
        repeat (230) tick();
        chk("err_sticky", err_req, 1);
        chk("err_line_done_busy", busy, 0);
        wait_drain(20);
        pulse_fs();
        chk("err_cleared", err_req, 0);

        // frame_start at pixel 150 of line 5.
        for (int unsigned l = 0; l < 5; l++) begin
            run_line(l, 1'b0);
        end
        r = cyc;
        push_pixels(5 * W, r, 1'b0, 151 - TB_LAT);
        pulse_req();
        repeat (150) tick();
        pulse_fs();
        chk("abort_lb_en", lb_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_addr", fb_addr, 0);
        repeat (10) tick();
        wait_drain(5);
        r = cyc;
        push_pixels(0, r, 1'b0, W);
        pulse_req();
        chk("abort_restart_addr", fb_addr, 0);
        chk("abort_restart_busy", busy, 1);
        repeat (W) tick();
        wait_drain(20);

        // frame_start and line_req together: request dropped.
        frame_start = 1'b1;
        line_req = 1'b1;
        tick();
        frame_start = 1'b0;
        line_req = 1'b0;
        chk("same_cycle_busy", busy, 0);
        chk("same_cycle_addr", fb_addr, 0);
        r = cyc;
        push_pixels(0, r, 1'b0, W);
        pulse_req();
        chk("same_cycle_next_addr", fb_addr, 0);
        chk("same_cycle_next_busy", busy, 1);
        repeat (W) tick();
        wait_drain(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_line_reader.md
# fb_line_reader

Streams one framebuffer line at a time into the linebuffer on request, forming the read side of the double-buffered framebuffer that the drawing engine writes. On each linebuffer data request it issues FB_WIDTH sequential read addresses to the selected framebuffer BRAM. It maps each returned colour index through the external palette ROM and presents colour with a latency-matched write enable. It sits between the framebuffer read-port mux and the linebuffer input, in the pixel clock domain.

## Interface
- FB_WIDTH, 320: pixels per framebuffer line.
- FB_HEIGHT, 240: lines per frame.
- FB_ADDRW, $clog2(FB_WIDTH*FB_HEIGHT): framebuffer address width.
- FB_DATAW, 4: colour index width.
- COLRW, 12: palette colour width, packed {r,g,b}.

Ports:
- clk  in  1  pixel clock; one clock for the whole block.
- rst  in  1  reset, synchronous and active-high.
- frame_start  in  1  one-cycle pulse at the start of vertical blanking; arms a new frame.
- line_req  in  1  linebuffer data request; one-cycle pulse.
- fb_addr  out  FB_ADDRW  framebuffer read address, registered.
- fb_cidx  in  FB_DATAW  framebuffer read data; valid one cycle after fb_addr.
- clut_idx  out  FB_DATAW  palette ROM address.
- clut_colr  in  COLRW  palette ROM data; combinational from clut_idx.
- lb_en  out  1  linebuffer write enable.
- lb_colr  out  COLRW  linebuffer colour data.
- busy  out  1  high while a line is being issued (state READ).
- frame_done  out  1  one-cycle pulse when the last pixel of the frame leaves on lb_en.
- err_req  out  1  sticky flag: line_req arrived during READ; cleared by frame_start.

## Operation
- States and transitions:
  - IDLE to WAIT (on frame_start).
  - WAIT to READ (on line_req).
  - READ to WAIT (after the last pixel of a line, when lines remain).
  - READ to IDLE (after pixel FB_WIDTH-1 of line FB_HEIGHT-1).
- frame_start in any state:
  - fb_addr, pixel counter and line counter reset to 0; state becomes WAIT.
  - In-flight pipeline valid bits are cleared, so no stale lb_en reaches the linebuffer.
- frame_start has priority over line_req in the same cycle; that line_req is dropped.
- line_req in IDLE is ignored silently (covers the final display line and requests after the frame completes).
- line_req in READ is ignored and sets err_req.
- Address arithmetic:
  - fb_addr increments by 1 per READ cycle and continues linearly across lines.
  - fb_addr is never advanced past FB_WIDTH*FB_HEIGHT-1; it holds there in IDLE until the next frame_start.
- Pixel counter width is $clog2(FB_WIDTH); line counter width is $clog2(FB_HEIGHT).
- clut_idx is the fb_cidx value, registered or not per Configuration. lb_colr is clut_colr registered.
- Reset values: state IDLE; fb_addr 0; counters 0; lb_en 0; lb_colr 0; busy 0; frame_done 0; err_req 0.
- Reset mid-line: all state is discarded; no lb_en is asserted until after the next frame_start and line_req.

## Timing
- line_req accepted at cycle R: READ occupies cycles R+1 to R+FB_WIDTH, issuing addresses base+0 to base+FB_WIDTH-1.
- busy is high for exactly FB_WIDTH cycles.
- Pipeline latency LAT from fb_addr to lb_en/lb_colr is 2 cycles by default, or 3 with the Configuration macro.
- Pixel k appears on lb_en at cycle R+1+k+LAT.
- lb_en is high for exactly FB_WIDTH contiguous cycles per line, with no gaps.
- The earliest next line_req is accepted on cycle R+FB_WIDTH+1 (back-to-back lines allowed).
- frame_done is coincident with the final lb_en of line FB_HEIGHT-1.

## Configuration
- FB_READ_REG_EN defined:
  - An extra register is inserted between fb_cidx and clut_idx for BRAM-to-ROM timing.
  - LAT=3; the lb_en valid pipeline gains one stage to match.
- Not defined: clut_idx = fb_cidx directly; LAT=2.

## Structure
- Shared package fb_pkg:
  - state enum type (IDLE, WAIT, READ);
  - default FB_WIDTH, FB_HEIGHT, FB_DATAW and COLRW constants;
  - a LAT constant derived from FB_READ_REG_EN.
- One sub-module, fb_read_pipe: parameterised valid/data delay line of depth LAT, with a synchronous flush input driven by frame_start.

## Test plan
- Reset, frame_start, one line_req with FB_WIDTH=320 -> fb_addr 0..319 on 320 consecutive cycles; lb_en high for 320 cycles starting LAT+1 after the request; lb_colr equals the palette entry for each stored index.
- Full frame of 240 requests at 800-cycle spacing:
  - line 239 uses addresses 76480..76799;
  - frame_done pulses once with the last lb_en;
  - a 241st line_req yields no lb_en.
- line_req issued 100 cycles into READ -> err_req goes to 1 and stays set; the line still completes 320 pixels. The next frame_start clears err_req.
- frame_start pulsed at pixel 150 of line 5:
  - lb_en drops within one cycle and no stale pixels follow;
  - the next line_req restarts at fb_addr 0.
- frame_start and line_req in the same cycle -> state WAIT and no READ; a line_req one cycle later starts at fb_addr 0.
- Build with FB_READ_REG_EN -> first lb_en exactly one cycle later than the default build, with identical lb_colr sequence.
